// File: rtl/i2c_seq_pkg.sv
// ----------------------------------------------------------------------------
// i2c_seq_pkg : opcodes, entry field positions and FSM states  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package i2c_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } op_e;

  localparam int ENTRY_W = 33;
  localparam int OP_HI   = 32;
  localparam int OP_LO   = 31;
  localparam int ADDR_HI = 30;
  localparam int ADDR_LO = 24;
  localparam int REG_HI  = 23;
  localparam int REG_LO  = 16;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    CAPTURE   = 3'd4,
    DELAY     = 3'd5,
    NEXT      = 3'd6,
    FINISH    = 3'd7
  } state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_sequencer_sync2.sv
// ----------------------------------------------------------------------------
// sync2 : generic 2-flop synchronizer for a single bit  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/i2c_sequencer.sv
// ----------------------------------------------------------------------------
// i2c_sequencer : table-driven command sequencer feeding an I2C controller  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module i2c_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               cmd_wr_en,
  input  logic [AW-1:0]      cmd_wr_addr,
  input  logic [ENTRY_W-1:0] cmd_wr_data,
  output logic               i2c_en,
  output logic [6:0]         i2c_addr,
  output logic [7:0]         i2c_reg,
  output logic               i2c_rw,
  output logic [15:0]        i2c_din,
  input  logic               i2c_busy,
  input  logic [15:0]        i2c_dout,
  output logic [15:0]        rd_data,
  output logic               rd_valid,
  output logic [AW-1:0]      rd_index,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               seq_error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e             state_q;
  logic [AW-1:0]      pc_q;
  logic               en_q;
  logic [6:0]         addr_q;
  logic [7:0]         reg_q;
  logic               rw_q;
  logic [15:0]        din_q;
  logic [15:0]        rd_data_q;
  logic               rd_valid_q;
  logic [AW-1:0]      rd_index_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;
  logic               is_read_q;
  logic               abort_pend_q;
  logic [15:0]        dly_q;
  logic [TW-1:0]      tmo_q;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] entry_q;
  logic [AW-1:0]      rd_addr_d;
  logic               busy_s;
  op_e                op_w;
  logic               tmo_hit_w;

  sync2 u_busy_sync (
    .clk (clk),
    .rst (rst),
    .d_i (i2c_busy),
    .q_o (busy_s)
  );

  // Address the RAM one cycle ahead so the entry is ready when FETCH is entered
  always_comb begin
    rd_addr_d = pc_q;
    if (state_q == IDLE) begin
      rd_addr_d = '0;
    end else if (state_q == NEXT) begin
      rd_addr_d = pc_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_wr_en) begin
      mem_q[cmd_wr_addr] <= cmd_wr_data;
    end
    entry_q <= (cmd_wr_en && (cmd_wr_addr == rd_addr_d)) ? cmd_wr_data : mem_q[rd_addr_d];
  end

  assign op_w      = op_e'(entry_q[OP_HI:OP_LO]);
  assign tmo_hit_w = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      en_q         <= 1'b0;
      addr_q       <= '0;
      reg_q        <= '0;
      rw_q         <= 1'b0;
      din_q        <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_index_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      is_read_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      dly_q        <= '0;
      tmo_q        <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            error_q <= 1'b0;
            pc_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            case (op_w)
              OP_WRITE, OP_READ: begin
                addr_q       <= entry_q[ADDR_HI:ADDR_LO];
                reg_q        <= entry_q[REG_HI:REG_LO];
                din_q        <= entry_q[DATA_HI:DATA_LO];
                rw_q         <= (op_w == OP_READ);
                is_read_q    <= (op_w == OP_READ);
                en_q         <= 1'b1;
                tmo_q        <= '0;
                abort_pend_q <= 1'b0;
                state_q      <= ISSUE;
              end
              OP_DELAY: begin
                dly_q   <= entry_q[DATA_HI:DATA_LO];
                state_q <= DELAY;
              end
              default: state_q <= FINISH;
            endcase
          end
        end
        ISSUE: begin
          if (abort) abort_pend_q <= 1'b1;
          if (busy_s) begin
            tmo_q   <= '0;
            state_q <= WAIT_DONE;
          end else if (tmo_hit_w) begin
            en_q    <= 1'b0;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (abort) abort_pend_q <= 1'b1;
          // en must fall here, otherwise the controller re-arms from READY
          if (!busy_s) begin
            en_q <= 1'b0;
            if (is_read_q) begin
              state_q <= CAPTURE;
            end else if (abort_pend_q || abort) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= NEXT;
            end
          end else if (tmo_hit_w) begin
            en_q    <= 1'b0;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        CAPTURE: begin
          rd_data_q  <= i2c_dout;
          rd_valid_q <= 1'b1;
          rd_index_q <= pc_q;
          if (abort_pend_q || abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= NEXT;
          end
        end
        DELAY: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (dly_q == 16'd0) begin
            state_q <= NEXT;
          end else begin
            dly_q <= dly_q - 16'd1;
          end
        end
        NEXT: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (pc_q == AW'(DEPTH - 1)) begin
            state_q <= FINISH;
          end else begin
            pc_q    <= pc_q + AW'(1);
            state_q <= FETCH;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i2c_en    = en_q;
  assign i2c_addr  = addr_q;
  assign i2c_reg   = reg_q;
  assign i2c_rw    = rw_q;
  assign i2c_din   = din_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_index  = rd_index_q;
  assign seq_busy  = busy_q;
  assign seq_done  = done_q;
  assign seq_error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_sequencer.sv
// ----------------------------------------------------------------------------
// tb_i2c_sequencer : directed bench with a simple I2C controller model  (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_i2c_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cmd_wr_en = 1'b0;
  logic [3:0]  cmd_wr_addr = '0;
  logic [32:0] cmd_wr_data = '0;
  logic        i2c_busy = 1'b0;
  logic [15:0] i2c_dout = '0;
  logic        i2c_en;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_reg;
  logic        i2c_rw;
  logic [15:0] i2c_din;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [3:0]  rd_index;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_error;

  int n_vec = 0;
  int n_mis = 0;

  i2c_sequencer #(.DEPTH(16), .AW(4), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cmd_wr_en(cmd_wr_en), .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
    .i2c_en(i2c_en), .i2c_addr(i2c_addr), .i2c_reg(i2c_reg), .i2c_rw(i2c_rw),
    .i2c_din(i2c_din), .i2c_busy(i2c_busy), .i2c_dout(i2c_dout),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  // Controller model and monitors, all sampled on the falling edge
  logic        m_dead = 1'b0;
  logic [15:0] m_rdata = '0;
  int m_phase = 0, m_cnt = 0, cyc = 0;
  logic en_prev = 1'b0;
  int txn_cnt = 0, en_rise_cnt = 0, en_fall_cnt = 0, busy_fall_cnt = 0;
  int rv_cnt = 0, done_cnt = 0;
  int en_rise_log [64];
  int en_fall_log [64];
  int busy_fall_log [64];
  logic [15:0] rv_data = '0, t_din = '0;
  logic [3:0]  rv_idx = '0;
  logic [6:0]  t_addr = '0;
  logic [7:0]  t_reg = '0;
  logic        t_rw = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (i2c_en && !en_prev) begin en_rise_log[en_rise_cnt % 64] = cyc; en_rise_cnt++; end
    if (!i2c_en && en_prev) begin en_fall_log[en_fall_cnt % 64] = cyc; en_fall_cnt++; end
    en_prev = i2c_en;
    if (rd_valid) begin rv_cnt++; rv_data = rd_data; rv_idx = rd_index; end
    if (seq_done) done_cnt++;
    case (m_phase)
      0: if (i2c_en && !m_dead) begin
        m_phase = 1; m_cnt = 0; txn_cnt++;
        t_rw = i2c_rw; t_din = i2c_din; t_addr = i2c_addr; t_reg = i2c_reg;
      end
      1: begin m_cnt++; if (m_cnt == 3) begin i2c_busy = 1'b1; m_cnt = 0; m_phase = 2; end end
      2: begin
        m_cnt++;
        if (m_cnt == 12) begin
          i2c_busy = 1'b0; i2c_dout = m_rdata;
          busy_fall_log[busy_fall_cnt % 64] = cyc; busy_fall_cnt++;
          m_cnt = 0; m_phase = 3;
        end
      end
      default: begin m_cnt++; if (m_cnt == 5) m_phase = 0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input logic [1:0] op, input logic [6:0] a7,
                      input logic [7:0] rg, input logic [15:0] d);
    cmd_wr_en = 1'b1; cmd_wr_addr = idx[3:0]; cmd_wr_data = {op, a7, rg, d};
    @(negedge clk);
    cmd_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!seq_busy) break;
      @(negedge clk);
    end
    check(tag, seq_busy, 0);
    repeat (30) @(negedge clk);
  endtask

  task automatic wait_model_busy(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (i2c_busy) break;
      @(negedge clk);
    end
    check(tag, i2c_busy, 1);
  endtask

  int s_txn, s_rise, s_bfall, s_rv, s_done, d;

  task automatic snap();
    s_txn = txn_cnt; s_rise = en_rise_cnt; s_bfall = busy_fall_cnt;
    s_rv = rv_cnt; s_done = done_cnt;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_en", i2c_en, 0);
    check("rst_busy", seq_busy, 0);
    check("rst_done", seq_done, 0);
    check("rst_err", seq_error, 0);
    check("rst_rv", rd_valid, 0);
    check("rst_din", i2c_din, 0);
    rst = 1'b0;
    @(negedge clk);

    // single write
    load(0, 2'b00, 7'h48, 8'h01, 16'hA5C3);
    load(1, 2'b11, 7'h00, 8'h00, 16'h0000);
    snap(); pulse_start(); wait_idle("w_idle", 300);
    check("w_txn", txn_cnt - s_txn, 1);
    check("w_rw", t_rw, 0);
    check("w_din", t_din, 16'hA5C3);
    check("w_addr", t_addr, 7'h48);
    check("w_reg", t_reg, 8'h01);
    check("w_done", done_cnt - s_done, 1);
    check("w_en_after_fall",
          en_fall_log[(en_fall_cnt - 1) % 64] > busy_fall_log[(busy_fall_cnt - 1) % 64], 1);

    // read capture
    m_rdata = 16'h33BE;
    load(0, 2'b01, 7'h1D, 8'h0F, 16'h0000);
    snap(); pulse_start(); wait_idle("r_idle", 300);
    check("r_rw", t_rw, 1);
    check("r_rv_cycles", rv_cnt - s_rv, 1);
    check("r_data", rv_data, 16'h33BE);
    check("r_index", rv_idx, 0);
    check("r_done", done_cnt - s_done, 1);

    // mixed list
    m_rdata = 16'h5A17;
    load(0, 2'b00, 7'h20, 8'h10, 16'h1234);
    load(1, 2'b10, 7'h00, 8'h00, 16'd100);
    load(2, 2'b01, 7'h21, 8'h11, 16'h0000);
    load(3, 2'b11, 7'h00, 8'h00, 16'h0000);
    snap(); pulse_start(); wait_idle("m_idle", 600);
    d = en_rise_log[(s_rise + 1) % 64] - busy_fall_log[s_bfall % 64];
    check("m_delay_gap", d >= 100, 1);
    check("m_txn", txn_cnt - s_txn, 2);
    check("m_rv_cycles", rv_cnt - s_rv, 1);
    check("m_index", rv_idx, 2);
    check("m_data", rv_data, 16'h5A17);

    // timeout
    m_dead = 1'b1;
    load(0, 2'b00, 7'h30, 8'h02, 16'hBEEF);
    load(1, 2'b11, 7'h00, 8'h00, 16'h0000);
    snap(); pulse_start(); wait_idle("t_idle", 300);
    check("t_en_len", en_fall_log[(en_fall_cnt - 1) % 64] - en_rise_log[(en_rise_cnt - 1) % 64], 50);
    check("t_err", seq_error, 1);
    check("t_done", done_cnt - s_done, 0);
    m_dead = 1'b0;
    snap(); pulse_start(); wait_idle("t2_idle", 300);
    check("t2_err_clr", seq_error, 0);
    check("t2_done", done_cnt - s_done, 1);

    // abort mid-transfer
    load(0, 2'b00, 7'h40, 8'h00, 16'h0001);
    load(1, 2'b00, 7'h40, 8'h01, 16'h0002);
    load(2, 2'b00, 7'h40, 8'h02, 16'h0003);
    load(3, 2'b11, 7'h00, 8'h00, 16'h0000);
    snap(); pulse_start();
    wait_model_busy("a_busy_seen");
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    wait_idle("a_idle", 300);
    check("a_bfall", busy_fall_cnt - s_bfall, 1);
    check("a_en_rises", en_rise_cnt - s_rise, 1);
    check("a_txn", txn_cnt - s_txn, 1);
    check("a_done", done_cnt - s_done, 0);

    // full table, no END
    for (int i = 0; i < 16; i++) load(i, 2'b00, 7'h50, 8'(i), 16'h1000 + 16'(i));
    snap(); pulse_start(); wait_idle("f_idle", 1500);
    check("f_txn", txn_cnt - s_txn, 16);
    check("f_done", done_cnt - s_done, 1);
    check("f_last_din", t_din, 16'h100F);
    check("f_last_reg", t_reg, 8'h0F);
    repeat (50) @(negedge clk);
    check("f_no_wrap", txn_cnt - s_txn, 16);

    // reset in the middle of a transfer
    pulse_start();
    wait_model_busy("x_busy_seen");
    rst = 1'b1;
    @(posedge clk); #1;
    check("x_en", i2c_en, 0);
    check("x_busy", seq_busy, 0);
    check("x_din", i2c_din, 0);
    check("x_addr", i2c_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
